spi_xfer_ctrl: RTL and testbench

- Word-level SPI master transaction controller. Sits directly downstream of spi_clk_gen.
- Drives spi_clk_gen's enable and consumes the SCLK it produces, using SCLK edges to shift MOSI out and sample MISO in.
- Frames each word with CS_n setup/hold timing for the DAQ ADC.
- SPI mode 1: CPOL=0, CPHA=1. MSB first.

---
 rtl/spi_xfer_ctrl.sv | 149 ++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_ctrl.sv
// ============================================================================
// spi_xfer_ctrl : word-level SPI mode-1 (CPOL=0, CPHA=1) master, MSB first,
//                 framing each word with CS_n setup/hold around spi_clk_gen SCLK.
// Optional macro SPI_LOOPBACK_EN adds loopback_i (sample MOSI instead of MISO).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_xfer_ctrl #(
  parameter int DATA_W          = 8,
  parameter int CS_SETUP_CYCLES = 4,
  parameter int CS_HOLD_CYCLES  = 4
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] tx_data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              sclk_en_o,
  input  logic              sclk_i,
  output logic              CS_n_o,
  output logic              MOSI_o,
  input  logic              MISO_i
`ifdef SPI_LOOPBACK_EN
  ,
  input  logic              loopback_i
`endif
);

  localparam int BIT_W   = $clog2(DATA_W);
  localparam int DLY_MAX = (CS_SETUP_CYCLES > CS_HOLD_CYCLES) ? CS_SETUP_CYCLES : CS_HOLD_CYCLES;
  localparam int DLY_W   = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;

  // Gray-sequenced so the decoded CS_n / sclk_en outputs change one state bit at a time
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SETUP = 2'b01;
  localparam logic [1:0] ST_SHIFT = 2'b11;
  localparam logic [1:0] ST_HOLD  = 2'b10;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              sclk_q;
  logic              rise;
  logic              fall;
  logic              last_bit;
  logic              dly_zero;
  logic              sample_bit;
  logic [DLY_W-1:0]  dly_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [DATA_W-1:0] rx_data_r;
  logic              mosi_r;
  logic              done_r;

  assign rise     = sclk_i & ~sclk_q;
  assign fall     = ~sclk_i & sclk_q;
  assign last_bit = (bit_cnt == BIT_W'(DATA_W - 1));
  assign dly_zero = (dly_cnt == '0);

`ifdef SPI_LOOPBACK_EN
  assign sample_bit = loopback_i ? mosi_r : MISO_i;
`else
  assign sample_bit = MISO_i;
`endif

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_i)         state_nxt = ST_SETUP;
      ST_SETUP: if (dly_zero)        state_nxt = ST_SHIFT;
      ST_SHIFT: if (fall && last_bit) state_nxt = ST_HOLD;
      ST_HOLD:  if (dly_zero)        state_nxt = ST_IDLE;
      default:                       state_nxt = ST_IDLE;
    endcase
  end

  // Framing outputs are pure state decodes; data outputs come straight from registers
  always_comb begin
    busy_o    = (state != ST_IDLE);
    CS_n_o    = (state == ST_IDLE);
    sclk_en_o = (state == ST_SHIFT);
    done_o    = done_r;
    MOSI_o    = mosi_r;
    rx_data_o = rx_data_r;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sclk_q    <= 1'b0;
      dly_cnt   <= '0;
      bit_cnt   <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      rx_data_r <= '0;
      mosi_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      sclk_q <= sclk_i;
      done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            tx_sr   <= tx_data_i;
            bit_cnt <= '0;
            dly_cnt <= DLY_W'(CS_SETUP_CYCLES - 1);
          end
        end
        ST_SETUP: begin
          if (!dly_zero) dly_cnt <= dly_cnt - 1'b1;
        end
        ST_SHIFT: begin
          if (rise) begin
            mosi_r <= tx_sr[DATA_W-1];
            tx_sr  <= {tx_sr[DATA_W-2:0], 1'b0};
          end
          if (fall) begin
            rx_sr   <= {rx_sr[DATA_W-2:0], sample_bit};
            bit_cnt <= bit_cnt + 1'b1;
            if (last_bit) dly_cnt <= DLY_W'(CS_HOLD_CYCLES - 1);
          end
        end
        ST_HOLD: begin
          if (dly_zero) begin
            mosi_r    <= 1'b0;
            rx_data_r <= rx_sr;
            done_r    <= 1'b1;
          end else begin
            dly_cnt <= dly_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_xfer_ctrl.sv
// ============================================================================
// tb_spi_xfer_ctrl : self-checking bench for spi_xfer_ctrl with a behavioural
//                    SCLK source and SPI slave; set SPI_LOOPBACK_EN for loopback.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_xfer_ctrl;

  localparam int DATA_W   = 8;
  localparam int CS_SETUP = 4;
  localparam int CS_HOLD  = 4;
  localparam int HALF     = 2;   // clock_i cycles per SCLK half-period (divide by 2**2)

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [DATA_W-1:0] tx_data = '0;
  logic              loopback = 1'b0;
  logic              sclk = 1'b0;
  logic              miso = 1'b0;
  logic              busy, done, sclk_en, cs_n, mosi;
  logic [DATA_W-1:0] rx;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  spi_xfer_ctrl #(
    .DATA_W(DATA_W), .CS_SETUP_CYCLES(CS_SETUP), .CS_HOLD_CYCLES(CS_HOLD)
  ) dut (
    .clock_i(clock), .reset_i(reset), .start_i(start), .tx_data_i(tx_data),
    .busy_o(busy), .done_o(done), .rx_data_o(rx), .sclk_en_o(sclk_en),
    .sclk_i(sclk), .CS_n_o(cs_n), .MOSI_o(mosi), .MISO_i(miso)
`ifdef SPI_LOOPBACK_EN
    , .loopback_i(loopback)
`endif
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc = cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // SCLK source standing in for spi_clk_gen: idles low, toggles every HALF cycles when enabled
  int div = 0;
  always @(posedge clock) begin
    if (!sclk_en) begin
      sclk <= 1'b0;
      div  <= 0;
    end else if (div == HALF - 1) begin
      sclk <= ~sclk;
      div  <= 0;
    end else begin
      div <= div + 1;
    end
  end

  // Values the DUT sees at each active edge, used to learn what an accepted start latched
  logic [DATA_W-1:0] tx_at_edge;
  logic              lb_at_edge;
  always @(posedge clock) begin
    tx_at_edge = tx_data;
`ifdef SPI_LOOPBACK_EN
    lb_at_edge = loopback;
`else
    lb_at_edge = 1'b0;
`endif
  end

  // Reference model: per-word expected MOSI stream and received word
  bit                armed = 0, aborted = 0, b2b = 0, slave_fixed_en = 0;
  logic [DATA_W-1:0] slave_fixed = '0, cur_slave = '0, mosi_bits = '0, last_mosi = '0;
  logic [DATA_W-1:0] tx_q[$], rx_q[$];
  int rises = 0, falls = 0, slave_idx = 0, n_done = 0, sclk_viol = 0;
  int t_cs_low = 0, t_last_fall = 0, t_cs_high = -1;
  logic prev_done = 1'b0;

  always @(negedge cs_n) if (armed) begin
    if (t_cs_high >= 0) begin
      if (b2b) check("cs_gap_b2b", cyc - t_cs_high, 1);
      else     check("cs_gap_min", 32'((cyc - t_cs_high) >= 1), 1);
    end
    t_cs_low  = cyc;
    rises     = 0;
    falls     = 0;
    mosi_bits = '0;
    slave_idx = DATA_W - 1;
    cur_slave = slave_fixed_en ? slave_fixed : DATA_W'($urandom);
    tx_q.push_back(tx_at_edge);
    rx_q.push_back(lb_at_edge ? tx_at_edge : cur_slave);
  end

  always @(posedge sclk_en) if (armed) check("en_setup_delay", cyc - t_cs_low, CS_SETUP);

  always @(posedge sclk) if (armed) begin
    rises++;
    if (slave_idx >= 0) begin
      miso = cur_slave[slave_idx];
      slave_idx--;
    end
  end

  always @(negedge sclk) if (armed) begin
    falls++;
    mosi_bits   = {mosi_bits[DATA_W-2:0], mosi};
    t_last_fall = cyc;
  end

  always @(posedge cs_n) if (armed) begin
    t_cs_high = cyc;
    if (aborted) begin
      aborted = 0;
      if (tx_q.size() > 0) void'(tx_q.pop_front());
      if (rx_q.size() > 0) void'(rx_q.pop_front());
    end else begin
      last_mosi = mosi_bits;
      check("cs_hold_delay", cyc - t_last_fall, CS_HOLD + 1);
      check("rise_count", rises, DATA_W);
      check("fall_count", falls, DATA_W);
      check("tx_pending", tx_q.size() > 0, 1);
      if (tx_q.size() > 0) check("mosi_stream", mosi_bits, tx_q.pop_front());
    end
  end

  always @(negedge clock) if (armed) begin
    if (cs_n && sclk) sclk_viol++;
    if (done) begin
      n_done++;
      check("done_width", prev_done, 0);
      check("rx_pending", rx_q.size() > 0, 1);
      if (rx_q.size() > 0) check("rx_data", rx, rx_q.pop_front());
    end
    prev_done = done;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done && k < budget) begin
      @(negedge clock);
      k++;
    end
    check("done_timeout", done, 1);
  endtask

  task automatic wait_falls(input int n, input int budget);
    int k = 0;
    while (falls < n && k < budget) begin
      @(negedge clock);
      k++;
    end
    check("falls_timeout", 32'(falls >= n), 1);
  endtask

  task automatic xfer(input logic [DATA_W-1:0] word, input bit lb);
    @(negedge clock);
    start = 1'b1; tx_data = word; loopback = lb;
    @(negedge clock);
    start = 1'b0; tx_data = DATA_W'($urandom);
    check("busy_after_start", busy, 1);
    check("cs_low_after_start", cs_n, 0);
    wait_done(400);
  endtask

  int done_base, expected_done = 0;
  bit lb;

  initial begin
    tick(3);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rx", rx, 0);
    check("rst_sclk_en", sclk_en, 0);
    check("rst_cs_n", cs_n, 1);
    check("rst_mosi", mosi, 0);
    reset = 1'b0;
    armed = 1;
    tick(2);

    // Directed 0xA5 out / 0x3C in
    slave_fixed_en = 1; slave_fixed = 8'h3C;
    xfer(8'hA5, 1'b0);
    expected_done++;
    tick(2);
    check("mosi_a5", last_mosi, 8'hA5);
    check("rx_3c", rx, 8'h3C);

    // Start while shifting is ignored
    slave_fixed = 8'h96;
    done_base = n_done;
    @(negedge clock); start = 1'b1; tx_data = 8'h5C;
    @(negedge clock); start = 1'b0;
    wait_falls(2, 200);
    start = 1'b1; tx_data = 8'hFF;
    @(negedge clock); start = 1'b0;
    wait_done(400);
    expected_done++;
    tick(2);
    check("rx_96", rx, 8'h96);
    check("mosi_5c", last_mosi, 8'h5C);
    tick(20);
    check("single_done", n_done, done_base + 1);
    check("no_restart", cs_n, 1);

    // Reset after the third falling edge
    slave_fixed_en = 0;
    done_base = n_done;
    @(negedge clock); start = 1'b1; tx_data = 8'h33;
    @(negedge clock); start = 1'b0;
    wait_falls(3, 200);
    aborted = 1;
    reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    check("abort_cs_n", cs_n, 1);
    check("abort_sclk_en", sclk_en, 0);
    check("abort_busy", busy, 0);
    check("abort_rx", rx, 0);
    check("abort_done", done, 0);
    tick(30);
    check("abort_no_done", n_done, done_base);
    xfer(DATA_W'($urandom), 1'b0);
    expected_done++;

    // start held high: back-to-back alternating words
    @(negedge clock); start = 1'b1; tx_data = 8'h00;
    for (int w = 0; w < 4; w++) begin
      begin : wait_cs
        int k = 0;
        while (cs_n && k < 20) begin
          @(negedge clock);
          k++;
        end
      end
      check("b2b_cs_low", cs_n, 0);
      b2b = 1;
      @(negedge clock);
      tx_data = (w % 2 == 0) ? 8'hFF : 8'h00;
      if (w == 3) start = 1'b0;
      wait_done(400);
      expected_done++;
    end
    @(negedge clock);
    b2b = 0;

    // Randomized words and gaps
    for (int i = 0; i < 10; i++) begin
`ifdef SPI_LOOPBACK_EN
      lb = 1'($urandom_range(0, 1));
`else
      lb = 1'b0;
`endif
      tick($urandom_range(0, 3));
      xfer(DATA_W'($urandom), lb);
      expected_done++;
    end

`ifdef SPI_LOOPBACK_EN
    slave_fixed_en = 1; slave_fixed = 8'h00;
    xfer(8'h5A, 1'b1);
    expected_done++;
    tick(2);
    check("loopback_on", rx, 8'h5A);
    xfer(8'h5A, 1'b0);
    expected_done++;
    tick(2);
    check("loopback_off", rx, 8'h00);
`endif

    tick(10);
    check("sclk_while_cs_high", sclk_viol, 0);
    check("done_total", n_done, expected_done);
    check("rx_queue_drained", rx_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
